// File: rtl/ysyx_23060042_pkg.sv
// Shared definitions for the ysyx_23060042 instruction fetch path.
// The reset PC constant is also used by the downstream PC-select logic.
package ysyx_23060042_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RESP_W = 2;

   localparam logic [RESP_W-1:0] RESP_OKAY        = 2'b00;
   localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_RESP  = 3'd1,
      S_ISSUE = 3'd2,
      S_EXEC  = 3'd3,
      S_ERR   = 3'd4
   } ifu_state_e;

endpackage : ysyx_23060042_pkg

// File: rtl/ysyx_23060042_ifu.sv
// Instruction fetch unit: one read per instruction, word handed to decode
// with valid/ready, then waits for the next PC before fetching again.
module ysyx_23060042_ifu
   import ysyx_23060042_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic [XLEN-1:0]   araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [XLEN-1:0]   rdata,
   input  logic [RESP_W-1:0] rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [XLEN-1:0]   inst,
   output logic [XLEN-1:0]   pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              npc_valid,
   input  logic [XLEN-1:0]   npc,
   output logic              fetch_err,
   output logic [CNT_W-1:0]  fetch_cnt
);

   ifu_state_e       state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  inst_q, inst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             arvalid_q, arvalid_d;
   logic             rready_q, rready_d;
   logic             inst_valid_q, inst_valid_d;

   // Handshake flags are registered copies of the next state, so they are
   // forced low during reset and never depend combinationally on inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      unique case (state_q)
         // arvalid lags the state by one cycle after reset; wait for it.
         S_REQ: begin
            if (arvalid_q && arready) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rvalid) begin
               if (rresp == RESP_OKAY) begin
                  inst_d  = rdata;
                  state_d = S_ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end
            end
         end
         S_ISSUE: begin
            if (inst_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (npc_valid) begin
               pc_d = npc;
               if (npc[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            err_d   = 1'b1;
            state_d = S_ERR;
         end
      endcase

      arvalid_d    = (state_d == S_REQ);
      rready_d     = (state_d == S_RESP);
      inst_valid_d = (state_d == S_ISSUE);
   end

   assign araddr     = pc_q;
   assign arvalid    = arvalid_q;
   assign rready     = rready_q;
   assign inst       = inst_q;
   assign pc         = pc_q;
   assign inst_valid = inst_valid_q;
   assign fetch_err  = err_q;
   assign fetch_cnt  = cnt_q;

endmodule : ysyx_23060042_ifu

// File: tb/tb_ysyx_23060042_ifu.sv
// Bench for ysyx_23060042_ifu: directed bus/decode stimulus with a
// scoreboard of expected {pc, inst} pairs popped on each decode handshake.
module tb_ysyx_23060042_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        npc_valid;
   logic [31:0] npc;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt;

   ysyx_23060042_ifu #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .araddr     (araddr),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rvalid     (rvalid),
      .rready     (rready),
      .inst       (inst),
      .pc         (pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .npc_valid  (npc_valid),
      .npc        (npc),
      .fetch_err  (fetch_err),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h want %08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each decode handshake must match the oldest delivered word.
   always @(negedge clk) begin
      if (!rst && inst_valid && inst_ready) begin
         check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("sb_inst", inst, mon_e.inst);
            check_eq("sb_pc", pc, mon_e.pc);
         end
      end
   end

   task automatic do_reset();
      rst        = 1'b1;
      arready    = 1'b0;
      rvalid     = 1'b0;
      rdata      = '0;
      rresp      = 2'b00;
      inst_ready = 1'b0;
      npc_valid  = 1'b0;
      npc        = '0;
      tick();
      tick();
      check_eq("rst_arvalid", 32'(arvalid), 32'd0);
      check_eq("rst_rready", 32'(rready), 32'd0);
      check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
      check_eq("rst_pc", pc, RST_PC);
      check_eq("rst_inst", inst, 32'd0);
      check_eq("rst_cnt", fetch_cnt, 32'd0);
      check_eq("rst_err", 32'(fetch_err), 32'd0);
      exp_cnt = '0;
      rst     = 1'b0;
      tick();
   endtask

   // Entered in the first cycle of S_REQ; returns in the first S_EXEC cycle.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                        input int ar_wait, input int r_wait, input int ir_wait,
                        input bit spur);
      for (int i = 0; i < ar_wait; i++) begin
         check_eq("arw_valid", 32'(arvalid), 32'd1);
         check_eq("arw_addr", araddr, addr);
         check_eq("arw_rready", 32'(rready), 32'd0);
         tick();
      end
      check_eq("req_valid", 32'(arvalid), 32'd1);
      check_eq("req_addr", araddr, addr);
      check_eq("req_rready", 32'(rready), 32'd0);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      for (int i = 0; i <= r_wait; i++) begin
         check_eq("resp_rready", 32'(rready), 32'd1);
         check_eq("resp_arvalid", 32'(arvalid), 32'd0);
         check_eq("resp_pc", pc, addr);
         if (i == r_wait) begin
            npc_valid = 1'b0;
            rvalid    = 1'b1;
            rdata     = word;
            rresp     = 2'b00;
            exp_q.push_back(exp_t'{pc: addr, inst: word});
         end else begin
            npc_valid = spur;
            npc       = 32'h1234_5678;
         end
         tick();
      end
      rvalid = 1'b0;
      rdata  = '0;
      for (int i = 0; i <= ir_wait; i++) begin
         check_eq("iss_valid", 32'(inst_valid), 32'd1);
         check_eq("iss_inst", inst, word);
         check_eq("iss_pc", pc, addr);
         check_eq("iss_cnt", fetch_cnt, exp_cnt);
         check_eq("iss_rready", 32'(rready), 32'd0);
         if (i == ir_wait) inst_ready = 1'b1;
         tick();
      end
      inst_ready = 1'b0;
      exp_cnt    = exp_cnt + 32'd1;
      check_eq("exe_valid", 32'(inst_valid), 32'd0);
      check_eq("exe_cnt", fetch_cnt, exp_cnt);
      check_eq("exe_inst", inst, word);
      check_eq("exe_pc", pc, addr);
      check_eq("exe_arvalid", 32'(arvalid), 32'd0);
   endtask

   task automatic give_npc(input logic [31:0] v);
      npc_valid = 1'b1;
      npc       = v;
      tick();
      npc_valid = 1'b0;
   endtask

   initial begin
      // Zero-wait fetch, then stalls on address, response and decode.
      do_reset();
      fetch(RST_PC, 32'h0000_0413, 0, 0, 0, 1'b0);
      give_npc(32'h8000_0004);
      fetch(32'h8000_0004, 32'h0010_0093, 5, 2, 4, 1'b1);
      give_npc(32'h8000_0008);
      fetch(32'h8000_0008, 32'h0020_8113, 1, 0, 0, 1'b0);

      // Misaligned next PC parks the unit in the error state.
      give_npc(32'h8000_0002);
      check_eq("mis_err", 32'(fetch_err), 32'd1);
      check_eq("mis_pc", pc, 32'h8000_0002);
      arready = 1'b1;
      rvalid  = 1'b1;
      rdata   = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         check_eq("mis_arvalid", 32'(arvalid), 32'd0);
         check_eq("mis_rready", 32'(rready), 32'd0);
         check_eq("mis_inst_valid", 32'(inst_valid), 32'd0);
         check_eq("mis_err_hold", 32'(fetch_err), 32'd1);
         check_eq("mis_inst", inst, 32'h0020_8113);
         tick();
      end

      // Bus error response.
      do_reset();
      check_eq("be_arvalid", 32'(arvalid), 32'd1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check_eq("be_rready", 32'(rready), 32'd1);
      rvalid = 1'b1;
      rresp  = 2'b10;
      rdata  = 32'hCAFE_BABE;
      tick();
      rvalid = 1'b0;
      rresp  = 2'b00;
      check_eq("be_err", 32'(fetch_err), 32'd1);
      check_eq("be_inst", inst, 32'd0);
      arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq("be_arvalid_off", 32'(arvalid), 32'd0);
         check_eq("be_inst_valid", 32'(inst_valid), 32'd0);
         check_eq("be_rready_off", 32'(rready), 32'd0);
         check_eq("be_err_hold", 32'(fetch_err), 32'd1);
         tick();
      end

      // Reset in the middle of a response, then a stale beat arrives.
      do_reset();
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check_eq("st_rready", 32'(rready), 32'd1);
      rst = 1'b1;
      tick();
      check_eq("st_rst_rready", 32'(rready), 32'd0);
      check_eq("st_rst_arvalid", 32'(arvalid), 32'd0);
      rst    = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      tick();
      check_eq("st_inst0", inst, 32'd0);
      check_eq("st_arvalid", 32'(arvalid), 32'd1);
      check_eq("st_araddr", araddr, RST_PC);
      tick();
      check_eq("st_inst1", inst, 32'd0);
      check_eq("st_rready_ign", 32'(rready), 32'd0);
      rvalid  = 1'b0;
      rdata   = '0;
      exp_cnt = '0;
      fetch(RST_PC, 32'h0000_0513, 0, 0, 0, 1'b0);

      check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ysyx_23060042_ifu
